// File: rtl/target_pkg.sv
// Shared types and default parameters for the reaction-game round controller.
package target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SHOW = 3'd3,
    ST_GAP  = 3'd4,
    ST_OVER = 3'd5
  } state_e;

  localparam int unsigned ARM_CYCLES = 2;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned LED_W      = 8;

  localparam int unsigned HOLD_CYCLES_DEF = 8;
  localparam int unsigned GAP_CYCLES_DEF  = 2;
  localparam int unsigned MAX_MISS_DEF    = 3;
  localparam int unsigned SCORE_W_DEF     = 4;

endpackage

// File: rtl/target_ctrl_idx_decode.sv
// Combinational 3-to-8 one-hot decoder driving the target LEDs.
module idx_decode
  import target_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [LED_W-1:0] onehot_c
);

  always_comb begin
    onehot_c        = '0;
    onehot_c[idx_i] = 1'b1;
  end

endmodule

// File: rtl/target_ctrl.sv
// Game-round controller: picks a target per round, judges presses, keeps score,
// and ends the game after MAX_MISS misses.
module target_ctrl
  import target_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned MAX_MISS    = MAX_MISS_DEF,
  parameter int unsigned SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic [2:0]         rnd,
  input  logic               press,
  input  logic [2:0]         press_idx,
  output logic [7:0]         leds,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int unsigned TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned MISS_W  = $clog2(MAX_MISS + 1);
  localparam int unsigned ARM_W   = $clog2(ARM_CYCLES + 1);

  state_e               state_q, state_d;
  logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [IDX_W-1:0]     tgt_q, tgt_d;
  logic [IDX_W-1:0]     round_q, round_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [LED_W-1:0]     leds_q, leds_d;
  logic                 game_over_q, game_over_d;
  logic [LED_W-1:0]     tgt_onehot;

  // Decode the next target so the LEDs light on the first SHOW cycle.
  idx_decode u_idx_decode (
    .idx_i    (tgt_d),
    .onehot_c (tgt_onehot)
  );

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    timer_d    = timer_q;
    gap_cnt_d  = gap_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tgt_d      = tgt_q;
    round_d    = round_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (active) begin
          state_d   = ST_ARM;
          arm_cnt_d = '0;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) state_d = ST_LOAD;
        else arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
      ST_LOAD: begin
        tgt_d   = rnd + round_q;
        timer_d = '0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        // A press in the final lit cycle wins over the timeout.
        if (press) begin
          if (press_idx == tgt_q) begin
            hit_d = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end else begin
            miss_d     = 1'b1;
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
          end
        end else if (timer_q == TIMER_W'(HOLD_CYCLES - 1)) begin
          miss_d     = 1'b1;
          miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
        if (hit_d || miss_d) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          round_d   = round_q + IDX_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = (miss_cnt_q == MISS_W'(MAX_MISS)) ? ST_OVER : ST_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping active abandons the game from any state.
    if (!active) begin
      state_d    = ST_IDLE;
      arm_cnt_d  = '0;
      timer_d    = '0;
      gap_cnt_d  = '0;
      miss_cnt_d = '0;
      tgt_d      = '0;
      round_d    = '0;
      score_d    = '0;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
    end

    leds_d      = '0;
    game_over_d = 1'b0;
    if (state_d == ST_SHOW) begin
      leds_d = tgt_onehot;
    end else if (state_d == ST_OVER) begin
      leds_d      = '1;
      game_over_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      arm_cnt_q   <= '0;
      timer_q     <= '0;
      gap_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      tgt_q       <= '0;
      round_q     <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      leds_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      timer_q     <= timer_d;
      gap_cnt_q   <= gap_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      tgt_q       <= tgt_d;
      round_q     <= round_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      leds_q      <= leds_d;
      game_over_q <= game_over_d;
    end
  end

  assign leds      = leds_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_target_ctrl.sv
// Self-checking bench for target_ctrl: round-level reference model, two instances
// (default score width and a 2-bit score) driven by the same stimulus.
module tb_target_ctrl;

  localparam int HOLD  = 8;
  localparam int GAP   = 2;
  localparam int MAXM  = 3;
  localparam int SMAXA = 15;
  localparam int SMAXB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic [2:0] rnd;
  logic       press;
  logic [2:0] press_idx;

  logic [7:0] leds_a, leds_b;
  logic       hit_a, hit_b, miss_a, miss_b, go_a, go_b;
  logic [3:0] score_a;
  logic [1:0] score_b;

  int checks   = 0;
  int failures = 0;

  // Model state: one game is a sequence of rounds
  int         round_m;
  int         hits_m;
  int         misses_m;
  logic [2:0] rnd_m;

  always #5 clk = ~clk;

  target_ctrl u_dut_a (
    .clk(clk), .reset(reset), .active(active), .rnd(rnd), .press(press),
    .press_idx(press_idx), .leds(leds_a), .hit(hit_a), .miss(miss_a),
    .score(score_a), .game_over(go_a)
  );

  target_ctrl #(.SCORE_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .active(active), .rnd(rnd), .press(press),
    .press_idx(press_idx), .leds(leds_b), .hit(hit_b), .miss(miss_b),
    .score(score_b), .game_over(go_b)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] onehot_m(input int i);
    logic [7:0] v;
    v = 8'(1 << i);
    return v;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk_outputs(input string tag, input logic [7:0] l, input logic h,
                             input logic m, input logic g);
    chk({tag, "_leds_a"}, 32'(leds_a), 32'(l));
    chk({tag, "_leds_b"}, 32'(leds_b), 32'(l));
    chk({tag, "_hit"},    32'({hit_a, hit_b}), 32'({h, h}));
    chk({tag, "_miss"},   32'({miss_a, miss_b}), 32'({m, m}));
    chk({tag, "_over"},   32'({go_a, go_b}), 32'({g, g}));
    chk({tag, "_score_a"}, 32'(score_a), 32'(sat(hits_m, SMAXA)));
    chk({tag, "_score_b"}, 32'(score_b), 32'(sat(hits_m, SMAXB)));
  endtask

  task automatic model_clear();
    round_m  = 0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic deactivate();
    active = 1'b0;
    step();
    model_clear();
    chk_outputs("deact", 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Raise active; rnd is junk for the first cycle, valid afterwards. Ends on first SHOW cycle.
  task automatic activate(input logic [2:0] r);
    rnd    = 3'($urandom);
    active = 1'b1;
    step();
    rnd   = r;
    rnd_m = r;
    chk_outputs("arm1", 8'h00, 1'b0, 1'b0, 1'b0);
    press     = 1'b1;
    press_idx = r;
    step();
    press = 1'b0;
    chk_outputs("arm2", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    chk_outputs("load", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // One round from its first SHOW cycle. press_at<0: never press. abort_at: drop active there.
  task automatic run_round(input int press_at, input bit correct, input int abort_at,
                           output bit over);
    int         t;
    bit         pressed;
    logic [2:0] pi;
    over    = 1'b0;
    pressed = 1'b0;
    t       = (int'(rnd_m) + round_m) % 8;
    for (int c = 0; c < HOLD; c++) begin
      chk_outputs("show", onehot_m(t), 1'b0, 1'b0, 1'b0);
      if (c == abort_at) begin
        deactivate();
        return;
      end
      if (c == press_at) begin
        pi        = correct ? 3'(t) : 3'((t + 1 + int'($urandom_range(0, 6))) % 8);
        press     = 1'b1;
        press_idx = pi;
        step();
        press   = 1'b0;
        pressed = 1'b1;
        break;
      end
      step();
    end
    if (pressed && correct) hits_m++;
    else misses_m++;
    round_m = (round_m + 1) % 8;
    chk_outputs("gap1", 8'h00, pressed && correct, !(pressed && correct), 1'b0);
    // A press during GAP must be ignored
    press     = 1'b1;
    press_idx = 3'((int'(rnd_m) + round_m) % 8);
    for (int g = 1; g < GAP; g++) begin
      step();
      press = 1'b0;
      chk_outputs("gapn", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    press = 1'b0;
    step();
    if (misses_m == MAXM) begin
      over = 1'b1;
      chk_outputs("over", 8'hFF, 1'b0, 1'b0, 1'b1);
    end else begin
      chk_outputs("reload", 8'h00, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    bit over;
    int kind;

    reset     = 1'b1;
    active    = 1'b0;
    rnd       = 3'd0;
    press     = 1'b0;
    press_idx = 3'd0;
    model_clear();
    rnd_m = 3'd0;
    step();
    chk_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk_outputs("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Game 1: five hits (2-bit score saturates), timeout, wrong key, timeout -> OVER
    activate(3'd5);
    chk("first_target", 32'(leds_a), 32'h20);
    run_round(2, 1'b1, -1, over);
    chk("second_target", 32'(leds_a), 32'h40);
    run_round(0, 1'b1, -1, over);
    run_round(HOLD - 1, 1'b1, -1, over);
    run_round(3, 1'b1, -1, over);
    run_round(5, 1'b1, -1, over);
    run_round(-1, 1'b0, -1, over);
    run_round(1, 1'b0, -1, over);
    run_round(-1, 1'b0, -1, over);
    chk("game1_over", 32'(over), 32'd1);
    for (int i = 0; i < 4; i++) begin
      press     = 1'b1;
      press_idx = 3'(i);
      step();
      chk_outputs("over_hold", 8'hFF, 1'b0, 1'b0, 1'b1);
    end
    press = 1'b0;
    deactivate();

    // Game 2: random rounds, then an active drop mid-SHOW
    activate(3'($urandom));
    run_round(int'($urandom_range(0, HOLD - 1)), 1'b1, -1, over);
    run_round(-1, 1'b0, int'($urandom_range(0, HOLD - 1)), over);
    activate(3'($urandom));
    over = 1'b0;
    for (int r = 0; r < 24 && !over; r++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1: run_round(int'($urandom_range(0, HOLD - 1)), 1'b1, -1, over);
        2:    run_round(int'($urandom_range(0, HOLD - 1)), 1'b0, -1, over);
        default: run_round(-1, 1'b0, -1, over);
      endcase
    end
    chk("game2_over", 32'(over), 32'd1);
    deactivate();

    // Async reset between edges while a target is lit
    activate(3'($urandom));
    chk("pre_reset_show", 32'(leds_a), 32'(onehot_m(int'(rnd_m))));
    step();
    #2;
    reset  = 1'b1;
    active = 1'b0;
    #1;
    model_clear();
    chk_outputs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    activate(3'($urandom));
    run_round(int'($urandom_range(0, HOLD - 1)), 1'b1, -1, over);
    deactivate();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
